// File: rtl/sdes_engine_ctrl.sv
// Multi-cycle S-DES encrypt/decrypt engine with valid/ready handshakes on both sides.
// Sequence: IP -> fk(Ka) -> SW -> fk(Kb) -> FP, each round held for STEP_CYCLES clocks.
module sdes_engine_ctrl #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
  input  logic       in_decrypt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StRnd1, StRnd2, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(STEP_CYCLES - 1);

  // S-boxes indexed by {row, col} = {b1, b4, b2, b3}
  localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                     2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                     2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  // Shared 8-bit permutation block: type 0 = IP, type 1 = FP (IP inverse)
  function automatic logic [7:0] perm8(input logic [7:0] x, input logic ptype);
    if (!ptype) return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    else        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // Rotate each 5-bit half left by one
  function automatic logic [9:0] ls1(input logic [9:0] a);
    return {a[8:5], a[9], a[3:0], a[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] y);
    return {y[4], y[7], y[3], y[6], y[2], y[5], y[0], y[1]};
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] t;
    logic [3:0] s;
    t = {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]} ^ k;
    s = {S0[{t[7], t[4], t[6], t[5]}], S1[{t[3], t[0], t[2], t[1]}]};
    return {x[7:4] ^ {s[2], s[0], s[1], s[3]}, x[3:0]};
  endfunction

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] k1_q, k1_d, k2_q, k2_d;
  logic       mode_q, mode_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       ready_q;

  logic [9:0] key_ls1;
  logic [7:0] ka, kb;
  logic       step_done;

  assign key_ls1   = ls1(p10(in_key));
  assign ka        = mode_q ? k2_q : k1_q;
  assign kb        = mode_q ? k1_q : k2_q;
  assign step_done = (cnt_q == LastCnt);

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);

  // Next-state and datapath sequencing
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      StIdle: begin
        if (in_valid && ready_q) begin
          data_d  = perm8(in_data, 1'b0);
          k1_d    = p8(key_ls1);
          k2_d    = p8(ls1(ls1(key_ls1)));
          mode_d  = in_decrypt;
          cnt_d   = '0;
          state_d = StRnd1;
        end
      end
      StRnd1: begin
        if (step_done) begin
          data_d  = {fk(data_q, ka)} << 4 | {fk(data_q, ka)} >> 4;
          cnt_d   = '0;
          state_d = StRnd2;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRnd2: begin
        if (step_done) begin
          out_data_d  = perm8(fk(data_q, kb), 1'b1);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; in_ready stays low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ready_q     <= (state_d == StIdle);
    end
  end

endmodule

// File: tb/tb_sdes_engine_ctrl.sv
// Self-checking bench for sdes_engine_ctrl: known vectors, backpressure, reset, slow stepping,
// and randomized encrypt/decrypt round trips against a table-driven S-DES model.
module tb_sdes_engine_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [9:0] in_key = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;

  logic       in_valid4 = 1'b0, in_decrypt4 = 1'b0, out_ready4 = 1'b0;
  logic [7:0] in_data4 = '0;
  logic [9:0] in_key4 = '0;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;

  int checks = 0;
  int failures = 0;

  localparam logic [9:0] KeyA = 10'b1010000010;
  localparam logic [7:0] PtA  = 8'b10010111;
  localparam logic [7:0] CtA  = 8'b00111000;

  sdes_engine_ctrl #(.STEP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  sdes_engine_ctrl #(.STEP_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_key(in_key4), .in_decrypt(in_decrypt4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (1-based permutation tables) ----------------
  localparam int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam int FP_T[10]  = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0_T[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_T[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic logic [9:0] perm(input logic [9:0] x, input int n_in, input int n_out,
                                      input int tab[10]);
    logic [9:0] r = '0;
    for (int j = 0; j < n_out; j++) r[n_out - 1 - j] = x[n_in - tab[j]];
    return r;
  endfunction

  function automatic int rotl5(input int v, input int n);
    return ((v << n) | (v >> (5 - n))) & 31;
  endfunction

  function automatic logic [7:0] fk_m(input logic [7:0] x, input logic [7:0] k);
    logic [9:0] e, p;
    logic [3:0] s;
    int r0, c0, r1, c1;
    e = perm({6'b0, x[3:0]}, 4, 8, EP_T);
    e[7:0] = e[7:0] ^ k;
    r0 = 2 * int'(e[7]) + int'(e[4]);
    c0 = 2 * int'(e[6]) + int'(e[5]);
    r1 = 2 * int'(e[3]) + int'(e[0]);
    c1 = 2 * int'(e[2]) + int'(e[1]);
    s = {2'(S0_T[r0][c0]), 2'(S1_T[r1][c1])};
    p = perm({6'b0, s}, 4, 4, P4_T);
    return {x[7:4] ^ p[3:0], x[3:0]};
  endfunction

  function automatic logic [7:0] sdes_m(input logic [7:0] d, input logic [9:0] key,
                                        input logic dec);
    logic [9:0] p, t;
    logic [7:0] k1, k2, x;
    int l, r;
    p  = perm(key, 10, 10, P10_T);
    l  = int'(p[9:5]);
    r  = int'(p[4:0]);
    t  = {5'(rotl5(l, 1)), 5'(rotl5(r, 1))};
    t  = perm(t, 10, 8, P8_T);
    k1 = t[7:0];
    t  = {5'(rotl5(l, 3)), 5'(rotl5(r, 3))};
    t  = perm(t, 10, 8, P8_T);
    k2 = t[7:0];
    t  = perm({2'b0, d}, 8, 8, IP_T);
    x  = fk_m(t[7:0], dec ? k2 : k1);
    x  = {x[3:0], x[7:4]};
    x  = fk_m(x, dec ? k1 : k2);
    t  = perm({2'b0, x}, 8, 8, FP_T);
    return t[7:0];
  endfunction

  // ---------------- drivers ----------------
  // Present a block and wait until it is accepted; leaves time #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic [9:0] k, input logic dec,
                      output bit ok, output logic busy_at_accept);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_key = k; in_decrypt = dec;
    ok = 1'b0;
    busy_at_accept = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin ok = 1'b1; busy_at_accept = busy; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready4 got=%b exp=1", in_ready4); end
  endtask

  task automatic test_encrypt();
    bit ok; logic b; int lat;
    send(PtA, KeyA, 1'b0, ok, b);
    checks++; if (!ok) begin failures++; $display("FAIL enc_accept got=timeout exp=accept"); end
    wait_out(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL enc_latency got=%0d exp=2", lat); end
    checks++; if (out_data !== CtA) begin failures++; $display("FAIL enc_data got=%b exp=%b", out_data, CtA); end
    checks++; if (out_data !== sdes_m(PtA, KeyA, 1'b0)) begin failures++; $display("FAIL enc_model got=%b exp=%b", out_data, sdes_m(PtA, KeyA, 1'b0)); end
  endtask

  // Holds the result from test_encrypt under backpressure while poking in_valid
  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); in_key = 10'($urandom); in_decrypt = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== CtA || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b d=%b rdy=%b busy=%b exp v=1 d=%b rdy=0 busy=1",
                 i, out_valid, out_data, in_ready, busy, CtA);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release_idle got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy); end
    checks++; if (out_data !== CtA) begin failures++; $display("FAIL bp_stale_data got=%b exp=%b", out_data, CtA); end
    if (bad != 0) failures++;
  endtask

  task automatic test_decrypt();
    bit ok; logic b; int lat;
    send(CtA, KeyA, 1'b1, ok, b);
    checks++; if (!ok) begin failures++; $display("FAIL dec_accept got=timeout exp=accept"); end
    wait_out(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL dec_latency got=%0d exp=2", lat); end
    checks++; if (out_data !== PtA) begin failures++; $display("FAIL dec_data got=%b exp=%b", out_data, PtA); end
    take_out();
  endtask

  task automatic test_reset_midop();
    bit ok; logic b; int lat;
    send(PtA, KeyA, 1'b0, ok, b);
    // now in the first round; prior result (PtA) is still on out_data
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", out_data); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial got=%b exp=0", out_valid); end
    send(PtA, KeyA, 1'b0, ok, b);
    wait_out(lat);
    checks++; if (lat != 2 || out_data !== CtA) begin failures++; $display("FAIL midrst_rerun got lat=%0d d=%b exp lat=2 d=%b", lat, out_data, CtA); end
    take_out();
  endtask

  task automatic test_step4();
    int lat = 0;
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = PtA; in_key4 = KeyA; in_decrypt4 = 1'b0;
    for (int i = 0; i < 20 && !in_ready4; i++) @(negedge clk);
    checks++; if (in_ready4 !== 1'b1) begin failures++; $display("FAIL step4_accept got=%b exp=1", in_ready4); end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat != 8) begin failures++; $display("FAIL step4_latency got=%0d exp=8", lat); end
    checks++; if (out_data4 !== CtA) begin failures++; $display("FAIL step4_data got=%b exp=%b", out_data4, CtA); end
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    checks++; if (out_valid4 !== 1'b0 || busy4 !== 1'b0) begin failures++; $display("FAIL step4_release got v=%b busy=%b exp v=0 busy=0", out_valid4, busy4); end
  endtask

  // Random round trips with random sink readiness
  task automatic test_back_to_back();
    logic [9:0] key;
    logic [7:0] pt, exp_v, got;
    bit ok, done;
    logic b;
    for (int n = 0; n < 16; n++) begin
      key = 10'($urandom);
      pt  = 8'($urandom);
      for (int pass = 0; pass < 2; pass++) begin
        exp_v = (pass == 0) ? sdes_m(pt, key, 1'b0) : pt;
        send((pass == 0) ? pt : got, key, pass[0], ok, b);
        checks++; if (!ok || b !== 1'b0) begin failures++; $display("FAIL b2b_accept_idle n=%0d p=%0d got ok=%0d busy=%b exp ok=1 busy=0", n, pass, ok, b); end
        done = 1'b0;
        got = '0;
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (in_ready && busy) begin
            checks++; failures++;
            $display("FAIL b2b_ready_busy n=%0d got rdy=1 busy=1 exp rdy=0", n);
          end
          if (out_valid && out_ready) begin
            got = out_data;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            done = 1'b1;
            break;
          end
        end
        out_ready = 1'b0;
        checks++; if (!done || got !== exp_v) begin failures++; $display("FAIL b2b_result n=%0d p=%0d got=%b exp=%b done=%0d", n, pass, got, exp_v, done); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_backpressure();
    test_decrypt();
    test_reset_midop();
    test_step4();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
